pwm_ramp_ctrl: RTL and testbench

- Controller that sequences the on-time fed to one PWM channel datapath.
- Ramps the channel's T_on from its current value toward a programmed target in fixed steps, one step every N PWM periods (soft start / soft stop).
- Sits between the per-channel bus registers and the PWM channel. Updates occur only on the channel's period-reload pulse, so a pulse is never truncated mid-period.

---
 rtl/pwm_ramp_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ramp_ctrl
//  Purpose  : Soft start / soft stop sequencer for one PWM channel. Moves the
//             channel on-time from its current value toward a programmed
//             target in fixed steps, one step every N PWM periods. Updates
//             happen only on the channel's period-reload pulse, so a pulse is
//             never cut short mid-period.
//  Ports    : clk, reset (async, active-low)
//             enable           - controller enable (level)
//             load             - 1-cycle pulse, latches target/step/interval
//             target_on        - requested final on-time
//             step             - on-time change per step (0 = jump)
//             periods_per_step - PWM periods between steps (0 treated as 1)
//             period_in        - current channel period, clamps the target
//             period_end       - 1-cycle period-reload pulse from the channel
//             T_on_out         - on-time presented to the channel
//             ramping          - high while ramping
//             at_target        - T_on_out equals the latched target
//             clamped          - last load had target_on > period_in
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
   parameter int DATA_W = 32,
   parameter int STEP_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              load,
   input  logic [DATA_W-1:0] target_on,
   input  logic [STEP_W-1:0] step,
   input  logic [CNT_W-1:0]  periods_per_step,
   input  logic [DATA_W-1:0] period_in,
   input  logic              period_end,
   output logic [DATA_W-1:0] T_on_out,
   output logic              ramping,
   output logic              at_target,
   output logic              clamped
);

   localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RAMP = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ton_q, ton_d;
   logic [DATA_W-1:0] tgt_q, tgt_d;
   logic [STEP_W-1:0] stp_q, stp_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              clamped_q, clamped_d;

   // Values captured by a load
   logic [DATA_W-1:0] w_load_tgt;
   logic              w_load_clamp;
   logic [CNT_W-1:0]  w_load_n;

   assign w_load_clamp = (target_on > period_in);
   assign w_load_tgt   = w_load_clamp ? period_in : target_on;
   assign w_load_n     = (periods_per_step == c_CNT_ZERO) ? c_CNT_ONE : periods_per_step;

   // One step toward the target. The extra MSB catches carry on the way up
   // and borrow on the way down, so the result saturates at the target
   // instead of wrapping or overshooting.
   logic [DATA_W:0]   w_stp_ext;
   logic [DATA_W:0]   w_up_sum;
   logic [DATA_W:0]   w_dn_diff;
   logic [DATA_W-1:0] w_step_val;

   assign w_stp_ext = {{(DATA_W+1-STEP_W){1'b0}}, stp_q};
   assign w_up_sum  = {1'b0, ton_q} + w_stp_ext;
   assign w_dn_diff = {1'b0, ton_q} - w_stp_ext;

   always_comb begin
      w_step_val = tgt_q;
      if (stp_q != '0) begin
         if (tgt_q > ton_q) begin
            if (w_up_sum < {1'b0, tgt_q})
               w_step_val = w_up_sum[DATA_W-1:0];
         end else begin
            if (!w_dn_diff[DATA_W] && (w_dn_diff[DATA_W-1:0] > tgt_q))
               w_step_val = w_dn_diff[DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         ton_q     <= '0;
         tgt_q     <= '0;
         stp_q     <= '0;
         n_q       <= c_CNT_ONE;
         cnt_q     <= '0;
         clamped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ton_q     <= ton_d;
         tgt_q     <= tgt_d;
         stp_q     <= stp_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         clamped_q <= clamped_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ton_d     = ton_q;
      tgt_d     = tgt_q;
      stp_d     = stp_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      clamped_d = clamped_q;

      // Load values are latched even while disabled
      if (load) begin
         tgt_d     = w_load_tgt;
         stp_d     = step;
         n_d       = w_load_n;
         clamped_d = w_load_clamp;
         cnt_d     = '0;
      end

      if (!enable) begin
         state_d = S_IDLE;
         ton_d   = '0;
         cnt_d   = '0;
      end else if (load) begin
         // Retarget from wherever T_on_out currently is; load beats period_end
         state_d = (ton_q != w_load_tgt) ? S_RAMP : S_HOLD;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Only reached with enable high right after a rising edge
               cnt_d   = '0;
               state_d = (ton_q != tgt_q) ? S_RAMP : S_HOLD;
            end
            S_RAMP: begin
               if (period_end) begin
                  if ((stp_q == '0) || (cnt_q == (n_q - c_CNT_ONE))) begin
                     cnt_d = '0;
                     ton_d = w_step_val;
                     if (w_step_val == tgt_q)
                        state_d = S_HOLD;
                  end else begin
                     cnt_d = cnt_q + c_CNT_ONE;
                  end
               end
            end
            S_HOLD: begin
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign T_on_out  = ton_q;
   assign ramping   = (state_q == S_RAMP);
   assign at_target = (ton_q == tgt_q);
   assign clamped   = clamped_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_ramp_ctrl
//  Purpose  : Self-checking bench for pwm_ramp_ctrl. Expected on-time values
//             (and the number of period_end pulses that must precede each
//             change) are queued as stimulus is issued and compared whenever
//             T_on_out changes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

   localparam int DATA_W = 32;
   localparam int STEP_W = 16;
   localparam int CNT_W  = 8;
   localparam int GAP    = 50;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic              load = 1'b0;
   logic [DATA_W-1:0] target_on = '0;
   logic [STEP_W-1:0] step = '0;
   logic [CNT_W-1:0]  periods_per_step = '0;
   logic [DATA_W-1:0] period_in = '0;
   logic              period_end = 1'b0;
   logic [DATA_W-1:0] T_on_out;
   logic              ramping;
   logic              at_target;
   logic              clamped;

   pwm_ramp_ctrl #(
      .DATA_W(DATA_W), .STEP_W(STEP_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .target_on(target_on), .step(step), .periods_per_step(periods_per_step),
      .period_in(period_in), .period_end(period_end), .T_on_out(T_on_out),
      .ramping(ramping), .at_target(at_target), .clamped(clamped)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      longint val;
      int     pes;   // period_end pulses expected before the change, -1 = any
   } exp_t;
   exp_t sb_q[$];

   int pe_total  = 0;  // period_end pulses the DUT has sampled (driver only)
   int load_mark = 0;  // pe_total at the most recent load (driver only)

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input longint v, input int pes);
      exp_t e;
      e.val = v;
      e.pes = pes;
      sb_q.push_back(e);
   endtask

   // Independent reference of the ramp sequence, at most nsteps entries
   task automatic push_ramp(input longint from, input longint tgt, input longint stp,
                            input int n, input int nsteps);
      longint v = from;
      for (int i = 0; i < nsteps && v != tgt; i++) begin
         if (stp == 0)        v = tgt;
         else if (tgt > v)    v = (v + stp > tgt) ? tgt : v + stp;
         else                 v = (v - stp < tgt) ? tgt : v - stp;
         push(v, (stp == 0) ? 1 : n);
      end
   endtask

   task automatic pulses(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk) #1;
         period_end = 1'b1;
         pe_total++;
         @(posedge clk) #1;
         period_end = 1'b0;
         repeat (GAP - 2) @(posedge clk);
      end
   endtask

   task automatic do_load(input longint tgt, input longint stp, input int n, input bit with_pe);
      @(posedge clk) #1;
      target_on        = DATA_W'(tgt);
      step             = STEP_W'(stp);
      periods_per_step = CNT_W'(n);
      load             = 1'b1;
      if (with_pe) begin
         period_end = 1'b1;
         pe_total++;
      end
      load_mark = pe_total;
      @(posedge clk) #1;
      load       = 1'b0;
      period_end = 1'b0;
   endtask

   // Scoreboard consumer: every change of T_on_out must match the queue head
   initial begin
      longint prev = 0;
      int     chg_mark = 0;
      exp_t   e;
      forever begin
         @(negedge clk);
         if (longint'(T_on_out) != prev) begin
            check_eq("sb_pending", longint'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check_eq("ton_value", longint'(T_on_out), e.val);
               if (e.pes >= 0)
                  check_eq("ton_periods", longint'(pe_total - ((chg_mark > load_mark) ? chg_mark : load_mark)),
                           longint'(e.pes));
            end
            prev     = longint'(T_on_out);
            chg_mark = pe_total;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      period_in = 5000;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ton", longint'(T_on_out), 0);
      check_eq("rst_at_target", longint'(at_target), 1);
      check_eq("rst_ramping", longint'(ramping), 0);
      check_eq("rst_clamped", longint'(clamped), 0);
      reset = 1'b1;
      @(posedge clk) #1;
      enable = 1'b1;
      repeat (3) @(posedge clk);

      // Soft start 0 -> 1000, step 100, every 2nd period
      push_ramp(0, 1000, 100, 2, 1000);
      do_load(1000, 100, 2, 1'b0);
      check_eq("up_ramping_start", longint'(ramping), 1);
      pulses(10);
      check_eq("up_ramping_mid", longint'(ramping), 1);
      check_eq("up_mid_ton", longint'(T_on_out), 500);
      pulses(10);
      check_eq("up_ton_final", longint'(T_on_out), 1000);
      check_eq("up_ramping_end", longint'(ramping), 0);
      check_eq("up_at_target", longint'(at_target), 1);
      pulses(2);  // HOLD ignores period_end

      // Ramp down with saturation at the target
      push_ramp(1000, 250, 300, 1, 1000);
      do_load(250, 300, 1, 1'b0);
      pulses(3);
      check_eq("dn_ton_final", longint'(T_on_out), 250);
      check_eq("dn_at_target", longint'(at_target), 1);
      check_eq("dn_ramping", longint'(ramping), 0);

      // Clamped jump
      period_in = 4000;
      push_ramp(250, 4000, 0, 1, 1000);
      do_load(9000, 0, 1, 1'b0);
      check_eq("clamp_flag", longint'(clamped), 1);
      pulses(1);
      check_eq("clamp_ton", longint'(T_on_out), 4000);
      period_in = 5000;

      // Disable, then load while disabled: values latched, output stays 0
      push(0, -1);
      @(posedge clk) #1;
      enable = 1'b0;
      @(posedge clk) #1;
      check_eq("dis_ton_next", longint'(T_on_out), 0);
      do_load(1000, 100, 2, 1'b0);
      check_eq("dis_load_ton", longint'(T_on_out), 0);
      check_eq("dis_load_ramping", longint'(ramping), 0);
      check_eq("dis_load_at_target", longint'(at_target), 0);
      check_eq("dis_load_clamped", longint'(clamped), 0);
      push_ramp(0, 1000, 100, 2, 3);
      enable = 1'b1;
      pulses(6);
      check_eq("en_ton_300", longint'(T_on_out), 300);
      check_eq("en_ramping", longint'(ramping), 1);

      // Drop enable mid-ramp, then re-raise
      push(0, -1);
      @(posedge clk) #1;
      enable = 1'b0;
      @(posedge clk) #1;
      check_eq("drop_ton", longint'(T_on_out), 0);
      check_eq("drop_ramping", longint'(ramping), 0);
      @(posedge clk) #1;
      enable = 1'b1;
      push_ramp(0, 1000, 100, 2, 3);
      pulses(6);
      check_eq("reen_ton", longint'(T_on_out), 300);

      // Load coinciding with period_end: no step, counter restarts
      pulses(1);
      period_in = 800;
      push_ramp(300, 800, 100, 2, 3);
      do_load(1000, 100, 2, 1'b1);
      check_eq("sim_ton_held", longint'(T_on_out), 300);
      check_eq("sim_clamped", longint'(clamped), 1);
      pulses(6);
      check_eq("sim_ton_600", longint'(T_on_out), 600);

      // Asynchronous reset mid-ramp
      pulses(1);
      push(0, -1);
      @(posedge clk) #1;
      reset = 1'b0;
      #2;
      check_eq("arst_ton", longint'(T_on_out), 0);
      check_eq("arst_at_target", longint'(at_target), 1);
      check_eq("arst_ramping", longint'(ramping), 0);
      check_eq("arst_clamped", longint'(clamped), 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("sb_drained", longint'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
